// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: bridges a valid/ready request/response port onto the
// five AXI4-Lite channels, one transaction in flight, with an optional
// response timeout and draining of stray B/R beats while idle.
module axi4_lite_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,   // 32 or 64
    parameter int unsigned TIMEOUT    = 1024, // 0 disables the timeout
    parameter logic [2:0]  PROT       = 3'b000
) (
    input  logic                      clk,
    input  logic                      reset,
    // IP request
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    // IP response
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    // write address channel
    output logic                      AWvalid,
    input  logic                      AWready,
    output logic [ADDR_WIDTH-1:0]     AWaddr,
    output logic [2:0]                AWprot,
    // write data channel
    output logic                      Wvalid,
    input  logic                      Wready,
    output logic [DATA_WIDTH-1:0]     Wdata,
    output logic [DATA_WIDTH/8-1:0]   Wstrb,
    // write response channel
    input  logic                      Bvalid,
    output logic                      Bready,
    input  logic [1:0]                Bresp,
    // read address channel
    output logic                      ARvalid,
    input  logic                      ARready,
    output logic [ADDR_WIDTH-1:0]     ARaddr,
    output logic [2:0]                ARprot,
    // read data channel
    input  logic                      Rvalid,
    output logic                      Rready,
    input  logic [DATA_WIDTH-1:0]     Rdata,
    input  logic [1:0]                Rresp
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP
    } state_t;

    state_t                    state, state_d;
    logic [CW-1:0]             cnt, cnt_d;
    logic                      awvalid_d, wvalid_d, arvalid_d;
    logic [ADDR_WIDTH-1:0]     awaddr_d, araddr_d;
    logic [DATA_WIDTH-1:0]     wdata_d, rsp_rdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_d;
    logic                      rsp_write_d, rsp_timeout_d;
    logic [1:0]                rsp_resp_d;
    logic                      timed_out;

    assign AWprot = PROT;
    assign ARprot = PROT;
    assign timed_out = (TIMEOUT != 0) && (cnt == TMO);

    // Next-state and next-value logic for every registered output.
    // The AW/W done flags are carried implicitly: a channel is done once its valid is low.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        awvalid_d     = AWvalid;
        wvalid_d      = Wvalid;
        arvalid_d     = ARvalid;
        awaddr_d      = AWaddr;
        araddr_d      = ARaddr;
        wdata_d       = Wdata;
        wstrb_d       = Wstrb;
        rsp_write_d   = rsp_write;
        rsp_rdata_d   = rsp_rdata;
        rsp_resp_d    = rsp_resp;
        rsp_timeout_d = rsp_timeout;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_write) begin
                        state_d   = WR_AW_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = req_addr;
                        wdata_d   = req_wdata;
                        wstrb_d   = req_wstrb;
                    end else begin
                        state_d   = RD_AR;
                        arvalid_d = 1'b1;
                        araddr_d  = req_addr;
                    end
                end
            end
            WR_AW_W: begin
                if (AWvalid && AWready) begin
                    awvalid_d = 1'b0;
                    awaddr_d  = '0;
                end
                if (Wvalid && Wready) begin
                    wvalid_d = 1'b0;
                    wdata_d  = '0;
                    wstrb_d  = '0;
                end
                if ((!AWvalid || AWready) && (!Wvalid || Wready))
                    state_d = WR_B;
            end
            WR_B: begin
                if (Bvalid && Bready) begin
                    state_d       = RSP;
                    rsp_write_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = Bresp;
                    rsp_timeout_d = 1'b0;
                end else if (timed_out) begin
                    state_d       = RSP;
                    rsp_write_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = 2'b10;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RD_AR: begin
                if (ARvalid && ARready) begin
                    state_d   = RD_R;
                    arvalid_d = 1'b0;
                    araddr_d  = '0;
                end
            end
            RD_R: begin
                if (Rvalid && Rready) begin
                    state_d       = RSP;
                    rsp_write_d   = 1'b0;
                    rsp_rdata_d   = Rdata;
                    rsp_resp_d    = Rresp;
                    rsp_timeout_d = 1'b0;
                end else if (timed_out) begin
                    state_d       = RSP;
                    rsp_write_d   = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = 2'b10;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d       = IDLE;
                    cnt_d         = '0;
                    rsp_write_d   = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = '0;
                    rsp_timeout_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transfer at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready   <= 1'b1;
            Bready      <= 1'b1;
            Rready      <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
            AWvalid     <= 1'b0;
            AWaddr      <= '0;
            Wvalid      <= 1'b0;
            Wdata       <= '0;
            Wstrb       <= '0;
            ARvalid     <= 1'b0;
            ARaddr      <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            req_ready   <= (state_d == IDLE);
            Bready      <= (state_d != RSP);
            Rready      <= (state_d != RSP);
            rsp_valid   <= (state_d == RSP);
            rsp_write   <= rsp_write_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_resp    <= rsp_resp_d;
            rsp_timeout <= rsp_timeout_d;
            AWvalid     <= awvalid_d;
            AWaddr      <= awaddr_d;
            Wvalid      <= wvalid_d;
            Wdata       <= wdata_d;
            Wstrb       <= wstrb_d;
            ARvalid     <= arvalid_d;
            ARaddr      <= araddr_d;
        end
    end

endmodule
